// File: rtl/count_check_pkg.sv
// rtl/count_check_pkg.sv - shared state encoding and default constants for count_checker
package count_check_pkg;

    localparam int DEF_WIDTH        = 4;
    localparam int DEF_LOCK_MATCHES = 2;
    localparam int DEF_ERR_W        = 8;

    // Wide enough for any lock threshold in 1..15.
    localparam int MATCH_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones, with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    // Clear has priority over increment; increment stops at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/count_checker.sv
// rtl/count_checker.sv - predicts a free-running counter and flags deviations once locked
module count_checker
    import count_check_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int LOCK_MATCHES = DEF_LOCK_MATCHES,
    parameter int ERR_W        = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] count,
    input  logic             clear_err,
    output logic             locked,
    output logic             mismatch,
    output logic             sticky_err,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count,
    output logic [WIDTH-1:0] expected
);

    localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_MATCHES - 1);

    state_t             state;
    state_t             state_next;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] match_cnt_next;
    logic [WIDTH-1:0]   count_q;
    logic               en_q;
    logic               hit;
    logic               wrap_hit;
    logic               sticky_q;

    // The prediction for this cycle is last cycle's count advanced by last cycle's enable.
    assign expected = count_q + WIDTH'(en_q);
    assign hit      = (count == expected);

    assign locked   = (state == ST_LOCKED);
    // Pulse is combinational so it lines up with the offending count sample.
    assign mismatch = locked && !hit;
    // A correct max-to-zero roll-over observed while locked.
    assign wrap_hit = locked && hit && en_q && (count_q == '1) && (count == '0);

    assign sticky_err = sticky_q;

    // Capture the observed count and enable every cycle to form the next prediction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            en_q    <= 1'b0;
        end else begin
            count_q <= count;
            en_q    <= enable;
        end
    end

    // State and consecutive-match counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            match_cnt <= '0;
        end else begin
            state     <= state_next;
            match_cnt <= match_cnt_next;
        end
    end

    // Next-state logic: IDLE only primes the history, ACQUIRE counts a run of hits, LOCKED drops out on any miss.
    always_comb begin
        state_next     = state;
        match_cnt_next = match_cnt;
        case (state)
            ST_IDLE: begin
                state_next     = ST_ACQUIRE;
                match_cnt_next = '0;
            end
            ST_ACQUIRE: begin
                if (hit) begin
                    if (match_cnt == LOCK_LAST) begin
                        state_next     = ST_LOCKED;
                        match_cnt_next = '0;
                    end else begin
                        match_cnt_next = match_cnt + 1'b1;
                    end
                end else begin
                    match_cnt_next = '0;
                end
            end
            ST_LOCKED: begin
                if (!hit) begin
                    state_next     = ST_ACQUIRE;
                    match_cnt_next = '0;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                match_cnt_next = '0;
            end
        endcase
    end

    // Sticky error flag; a clear in the same cycle as a mismatch leaves it low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sticky_q <= 1'b0;
        end else if (clear_err) begin
            sticky_q <= 1'b0;
        end else if (mismatch) begin
            sticky_q <= 1'b1;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_count (
        .clk   (clk),
        .reset (reset),
        .inc   (mismatch),
        .clr   (clear_err),
        .value (err_count)
    );

    sat_counter #(
        .W (ERR_W)
    ) u_wrap_count (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_hit),
        .clr   (1'b0),
        .value (wrap_count)
    );

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - randomized self-checking bench for count_checker
module tb_count_checker;

    localparam int W    = 4;
    localparam int LM   = 2;
    localparam int EW   = 8;
    localparam int MODV = 16;
    localparam int SAT  = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [W-1:0]  count;
    logic          clear_err;
    logic          locked;
    logic          mismatch;
    logic          sticky_err;
    logic [EW-1:0] err_count;
    logic [EW-1:0] wrap_count;
    logic [W-1:0]  expected;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_prev_cnt, m_prev_en, m_fresh, m_locked, m_streak, m_err, m_sticky, m_wrap;
    // predicted outputs for the cycle currently presented
    int p_exp, p_locked, p_mm, p_err, p_sticky, p_wrap;
    // value the well-behaved counter under check presents next
    int g_cnt;

    always #5 clk = ~clk;

    count_checker #(
        .WIDTH        (W),
        .LOCK_MATCHES (LM),
        .ERR_W        (EW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .count      (count),
        .clear_err  (clear_err),
        .locked     (locked),
        .mismatch   (mismatch),
        .sticky_err (sticky_err),
        .err_count  (err_count),
        .wrap_count (wrap_count),
        .expected   (expected)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic model_update();
        int c, e, exp_v;
        c = int'(count);
        e = int'(enable);
        if (reset == 1'b0) begin
            m_prev_cnt = 0; m_prev_en = 0; m_fresh = 1; m_locked = 0;
            m_streak = 0; m_err = 0; m_sticky = 0; m_wrap = 0;
        end else begin
            exp_v = (m_prev_cnt + m_prev_en) % MODV;
            if (m_fresh != 0) begin
                m_fresh = 0;
            end else if (m_locked != 0) begin
                if (c != exp_v) begin
                    if (m_err < SAT) m_err++;
                    m_sticky = 1;
                    m_locked = 0;
                    m_streak = 0;
                end else if (m_prev_cnt == MODV - 1 && m_prev_en == 1 && c == 0) begin
                    if (m_wrap < SAT) m_wrap++;
                end
            end else begin
                if (c == exp_v) begin
                    m_streak++;
                    if (m_streak >= LM) begin
                        m_locked = 1;
                        m_streak = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
            if (clear_err) begin
                m_err = 0;
                m_sticky = 0;
            end
            m_prev_cnt = c;
            m_prev_en  = e;
        end
    endtask

    task automatic cycle(input logic rst, input logic en, input int cnt, input logic clr);
        @(posedge clk);
        model_update();
        @(negedge clk);
        reset     = rst;
        enable    = en;
        count     = W'(cnt % MODV);
        clear_err = clr;
        #1;
        p_exp    = (m_prev_cnt + m_prev_en) % MODV;
        p_locked = m_locked;
        p_mm     = (m_locked != 0 && (cnt % MODV) != p_exp) ? 1 : 0;
        p_err    = m_err;
        p_sticky = m_sticky;
        p_wrap   = m_wrap;
    endtask

    task automatic good(input logic en);
        cycle(1'b1, en, g_cnt, 1'b0);
        g_cnt = (g_cnt + int'(en)) % MODV;
    endtask

    task automatic inject(input logic clr);
        int bad;
        bad = (g_cnt + 5) % MODV;
        cycle(1'b1, 1'b1, bad, clr);
        g_cnt = (bad + 1) % MODV;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 9, 1'b0);
        cycle(1'b0, 1'b1, 3, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0d want 0", locked); end
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %0d want 0", mismatch); end
        checks++; if (sticky_err !== 1'b0) begin errors++; $display("FAIL reset_sticky got %0d want 0", sticky_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_count); end
        checks++; if (wrap_count !== 8'd0) begin errors++; $display("FAIL reset_wrap got %0d want 0", wrap_count); end
        checks++; if (expected !== 4'd0) begin errors++; $display("FAIL reset_expected got %0d want 0", expected); end
    endtask

    task automatic test_lock_acquire();
        g_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            good(1'b1);
            checks++;
            if (locked !== (k >= 4)) begin
                errors++; $display("FAIL acquire_locked cycle %0d got %0d want %0d", k, locked, (k >= 4));
            end
        end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL acquire_err got %0d want 0", err_count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < MODV && g_cnt != MODV - 1; i++) good(1'b1);
        good(1'b1);
        good(1'b1);
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL wrap_mismatch got %0d want 0", mismatch); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_locked got %0d want 1", locked); end
        good(1'b1);
        checks++; if (wrap_count !== 8'd1) begin errors++; $display("FAIL wrap_count got %0d want 1", wrap_count); end
    endtask

    task automatic test_single_mismatch();
        for (int i = 0; i < MODV && g_cnt != 5; i++) good(1'b1);
        good(1'b1);
        cycle(1'b1, 1'b1, 7, 1'b0);
        g_cnt = 8;
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_pulse got %0d want 1", mismatch); end
        good(1'b1);
        checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mm_pulse_width got %0d want 0", mismatch); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mm_unlock got %0d want 0", locked); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL mm_err got %0d want 1", err_count); end
        checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL mm_sticky got %0d want 1", sticky_err); end
        good(1'b1);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mm_relock_early got %0d want 0", locked); end
        good(1'b1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mm_relock got %0d want 1", locked); end
    endtask

    task automatic test_enable_low();
        cycle(1'b1, 1'b1, g_cnt, 1'b1);
        g_cnt = (g_cnt + 1) % MODV;
        for (int i = 0; i < MODV && g_cnt != 6; i++) good(1'b1);
        for (int i = 0; i < 50; i++) begin
            good(1'b0);
            checks++;
            if (locked !== 1'b1 || mismatch !== 1'b0) begin
                errors++; $display("FAIL enlow_hold cycle %0d locked %0d mismatch %0d want 1 0", i, locked, mismatch);
            end
        end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL enlow_err got %0d want 0", err_count); end
        checks++; if (expected !== 4'd6) begin errors++; $display("FAIL enlow_expected got %0d want 6", expected); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            inject(1'b0);
            good(1'b1); good(1'b1); good(1'b1);
        end
        checks++; if (err_count !== 8'(SAT)) begin errors++; $display("FAIL sat_err got %0d want %0d", err_count, SAT); end
        checks++; if (err_count !== 8'(p_err)) begin errors++; $display("FAIL sat_err_model got %0d want %0d", err_count, p_err); end
        checks++; if (sticky_err !== 1'b1) begin errors++; $display("FAIL sat_sticky got %0d want 1", sticky_err); end
        cycle(1'b1, 1'b1, g_cnt, 1'b1);
        g_cnt = (g_cnt + 1) % MODV;
        good(1'b1);
        checks++; if (err_count !== 8'd0 || sticky_err !== 1'b0) begin
            errors++; $display("FAIL sat_clear err %0d sticky %0d want 0 0", err_count, sticky_err);
        end
        inject(1'b1);
        checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL clr_mm_pulse got %0d want 1", mismatch); end
        good(1'b1);
        checks++; if (err_count !== 8'd0 || sticky_err !== 1'b0) begin
            errors++; $display("FAIL clr_wins err %0d sticky %0d want 0 0", err_count, sticky_err);
        end
    endtask

    task automatic test_reset_mid_lock();
        good(1'b1); good(1'b1);
        for (int i = 0; i < 3; i++) begin
            inject(1'b0);
            good(1'b1); good(1'b1); good(1'b1);
        end
        checks++; if (locked !== 1'b1 || err_count !== 8'd3) begin
            errors++; $display("FAIL rml_pre locked %0d err %0d want 1 3", locked, err_count);
        end
        cycle(1'b0, 1'b1, 11, 1'b0);
        cycle(1'b0, 1'b1, 2, 1'b0);
        checks++; if (locked !== 1'b0 || mismatch !== 1'b0 || sticky_err !== 1'b0) begin
            errors++; $display("FAIL rml_flags locked %0d mm %0d sticky %0d want 0 0 0", locked, mismatch, sticky_err);
        end
        checks++; if (err_count !== 8'd0 || wrap_count !== 8'd0 || expected !== 4'd0) begin
            errors++; $display("FAIL rml_counts err %0d wrap %0d exp %0d want 0 0 0", err_count, wrap_count, expected);
        end
        g_cnt = 12;
        for (int k = 1; k <= 4; k++) begin
            good(1'b1);
            checks++;
            if (locked !== (k >= 4)) begin
                errors++; $display("FAIL rml_relock cycle %0d got %0d want %0d", k, locked, (k >= 4));
            end
        end
    endtask

    task automatic test_random();
        int   cnt;
        logic en, clr, rst;
        for (int i = 0; i < 2500; i++) begin
            en  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 199) != 0);
            cnt = g_cnt;
            if ($urandom_range(0, 15) == 0) cnt = (g_cnt + 1 + int'($urandom_range(0, 14))) % MODV;
            cycle(rst, en, cnt, clr);
            g_cnt = (cnt + int'(en)) % MODV;
            checks++; if (expected !== W'(p_exp)) begin errors++; $display("FAIL rnd_expected i=%0d got %0d want %0d", i, expected, p_exp); end
            checks++; if (locked !== 1'(p_locked)) begin errors++; $display("FAIL rnd_locked i=%0d got %0d want %0d", i, locked, p_locked); end
            checks++; if (mismatch !== 1'(p_mm)) begin errors++; $display("FAIL rnd_mismatch i=%0d got %0d want %0d", i, mismatch, p_mm); end
            checks++; if (sticky_err !== 1'(p_sticky)) begin errors++; $display("FAIL rnd_sticky i=%0d got %0d want %0d", i, sticky_err, p_sticky); end
            checks++; if (err_count !== EW'(p_err)) begin errors++; $display("FAIL rnd_err i=%0d got %0d want %0d", i, err_count, p_err); end
            checks++; if (wrap_count !== EW'(p_wrap)) begin errors++; $display("FAIL rnd_wrap i=%0d got %0d want %0d", i, wrap_count, p_wrap); end
        end
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        count     = '0;
        clear_err = 1'b0;
        g_cnt     = 0;
        test_reset();
        test_lock_acquire();
        test_wrap();
        test_single_mismatch();
        test_enable_low();
        test_saturation();
        test_reset_mid_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, width of the observed count bus.
REQ-002 SHALL have parameter LOCK_MATCHES, default 2, consecutive correct samples required to declare lock (range 1..15).
REQ-003 SHALL have parameter ERR_W, default 8, width of the error and wrap counters.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous active-low reset.
REQ-007 SHALL have port enable  input  1  enable observed at the counter under check.
REQ-008 SHALL have port count  input  WIDTH  count value driven by the counter under check.
REQ-009 SHALL have port clear_err  input  1  synchronous clear of err_count and sticky_err.
REQ-010 SHALL have port locked  output  1  high while in LOCKED state.
REQ-011 SHALL have port mismatch  output  1  one-cycle pulse on each detected mismatch in LOCKED.
REQ-012 SHALL have port sticky_err  output  1  set by any mismatch, held until clear_err or reset.
REQ-013 SHALL have port err_count  output  ERR_W  saturating mismatch count.
REQ-014 SHALL have port wrap_count  output  ERR_W  saturating count of observed max-to-0 wraps while LOCKED.
REQ-015 SHALL have port expected  output  WIDTH  registered prediction for the current cycle's count.

Function
REQ-016 SHALL model the checked counter as: count(n+1) = count(n) + enable(n) mod 2^WIDTH.
REQ-017 SHALL register count and enable every cycle (count_q, en_q); prediction expected = count_q + en_q, wrapping all-ones to 0.
REQ-018 SHALL implement states IDLE, ACQUIRE, LOCKED.
REQ-019 IDLE: first cycle after reset release captures count_q/en_q only, no compare; next state ACQUIRE.
REQ-020 ACQUIRE: each cycle compare count with expected; match increments match counter, mismatch clears it; reaching LOCK_MATCHES -> LOCKED next cycle.
REQ-021 ACQUIRE mismatches SHALL NOT pulse mismatch, set sticky_err or increment err_count.
REQ-022 LOCKED: mismatch SHALL pulse mismatch in the same cycle the bad count is present (combinational compare, registered pulse one cycle later is not allowed), set sticky_err, increment err_count, and return to ACQUIRE with match counter cleared.
REQ-023 LOCKED: when count_q is all-ones, en_q=1 and count=0 (a correct wrap), wrap_count SHALL increment.
REQ-024 err_count and wrap_count SHALL saturate at all-ones and never wrap.
REQ-025 clear_err coincident with a mismatch: clear wins; err_count=0, sticky_err=0 that cycle; mismatch pulse still asserted.
REQ-026 enable held low indefinitely SHALL be legal; a constant count matches and keeps lock.
REQ-027 expected SHALL update every cycle in all states except during reset.

Reset
REQ-028 reset=0 at a clock edge SHALL force state IDLE, match counter 0, count_q=0, en_q=0.
REQ-029 Reset values: locked=0, mismatch=0, sticky_err=0, err_count=0, wrap_count=0, expected=0.
REQ-030 Reset asserted mid-LOCKED SHALL discard lock; relock requires IDLE plus LOCK_MATCHES correct samples.

Structure
REQ-031 State encoding (IDLE/ACQUIRE/LOCKED) and default parameter constants SHALL live in shared package count_check_pkg.
REQ-032 Saturating counter SHALL be one sub-module, sat_counter (inc, clr, value), instantiated for err_count and wrap_count.

Verification
REQ-033 Reset 2 cycles, then count 0 with enable=1 incrementing -> locked=1 on cycle 4 after release (IDLE + 2 matches + transition), err_count=0.
REQ-034 Locked, count 15 with enable=1, next count 0 -> no mismatch, wrap_count=1.
REQ-035 Locked, count forced 5->7 with enable=1 -> mismatch pulse exactly 1 cycle, err_count=1, sticky_err=1, locked=0 next cycle, relock after 2 good samples.
REQ-036 Locked, enable=0 for 50 cycles at count 6 -> locked stays 1, err_count=0.
REQ-037 300 injected mismatches with relock between -> err_count=255 saturated; clear_err pulse -> err_count=0, sticky_err=0.
REQ-038 reset=0 mid-LOCKED with err_count=3 -> next cycle all outputs at reset values.
